icache_fill: RTL and testbench

Direct-mapped instruction cache that issues block read requests to the instruction memory and serves 32-bit instruction fetches to the core. It sits between the fetch stage and the instruction memory. Its memory port drives the address and read strobe and captures the returned block pair.

---
 rtl/icache_fill.sv | 152 +++++++++++++++
 tb/tb_icache_fill.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a single-block miss fill.
// Define ICACHE_PREFETCH_EN to also fill the next sequential line from mem_out2 on every miss.
module icache_fill #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int LINES      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_valid,
  output logic [WORD_SIZE-1:0]  cpu_inst,
  input  logic                  inv,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic                  mem_read,
  input  logic [BLOCK_SIZE-1:0] mem_out1,
  input  logic [BLOCK_SIZE-1:0] mem_out2
);

  // state  | meaning
  // IDLE   | ready for a fetch, latch address on cpu_req
  // LOOKUP | tag compare at latched index
  // MREQ   | mem_read pulse with block-aligned address
  // MWAIT  | memory block present, fill line and capture word
  // RESP   | cpu_valid pulse, back to IDLE

  localparam int OFF_W  = $clog2(BLOCK_SIZE/8);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(BLOCK_SIZE/WORD_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MREQ,
    S_MWAIT,
    S_RESP
  } state_t;

  state_t                 state;
  logic [WORD_SIZE-1:2]   addr_q;
  logic [LINES-1:0]       line_valid;
  logic [TAG_W-1:0]       line_tag  [LINES];
  logic [BLOCK_SIZE-1:0]  line_data [LINES];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [WSEL_W-1:0]      wsel;
  logic                   hit;

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign tag  = addr_q[WORD_SIZE-1 -: TAG_W];
  assign wsel = addr_q[OFF_W-1 -: WSEL_W];
  assign hit  = line_valid[idx] && (line_tag[idx] == tag);

`ifdef ICACHE_PREFETCH_EN
  localparam int BN_W = WORD_SIZE - OFF_W;

  // Next block number; carry out of the index field bumps the tag on wrap.
  logic [BN_W-1:0]  nxt_bn;
  logic [IDX_W-1:0] nxt_idx;
  logic [TAG_W-1:0] nxt_tag;
  logic             unused_bits;

  assign nxt_bn      = addr_q[WORD_SIZE-1:OFF_W] + BN_W'(1);
  assign nxt_idx     = nxt_bn[IDX_W-1:0];
  assign nxt_tag     = nxt_bn[BN_W-1 -: TAG_W];
  assign unused_bits = ^cpu_addr[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[1:0], mem_out2};
`endif

  // Word 0 lives in the most significant bits of the block.
  function automatic logic [WORD_SIZE-1:0] pick_word(input logic [BLOCK_SIZE-1:0] blk,
                                                     input logic [WSEL_W-1:0]     w);
    return blk[BLOCK_SIZE-1-int'(w)*WORD_SIZE -: WORD_SIZE];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      line_valid <= '0;
      cpu_ready  <= 1'b1;
      cpu_valid  <= 1'b0;
      cpu_inst   <= '0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
    end else begin
      cpu_valid <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q    <= cpu_addr[WORD_SIZE-1:2];
            cpu_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_inst  <= pick_word(line_data[idx], wsel);
            cpu_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            mem_read <= 1'b1;
            mem_addr <= {addr_q[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            state    <= S_MREQ;
          end
        end
        S_MREQ: begin
          state <= S_MWAIT;
        end
        S_MWAIT: begin
          line_valid[idx] <= 1'b1;
`ifdef ICACHE_PREFETCH_EN
          line_valid[nxt_idx] <= 1'b1;
`endif
          cpu_inst  <= pick_word(mem_out1, wsel);
          cpu_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
      // Invalidate wins over a same-edge fill; the response itself is unaffected.
      if (inv) line_valid <= '0;
    end
  end

  // Tag/data arrays need no reset: a line is only observed through its valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_MWAIT) begin
      line_tag[idx]  <= tag;
      line_data[idx] <= mem_out1;
`ifdef ICACHE_PREFETCH_EN
      line_tag[nxt_idx]  <= nxt_tag;
      line_data[nxt_idx] <= mem_out2;
`endif
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill against a block-address level cache model.
module tb_icache_fill;
  localparam int LINES = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic         inv = 1'b0;
  logic [127:0] mem_out1 = '0;
  logic [127:0] mem_out2 = '0;
  logic         cpu_ready, cpu_valid, mem_read;
  logic [31:0]  cpu_inst, mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  icache_fill #(.WORD_SIZE(32), .BLOCK_SIZE(128), .LINES(LINES)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_inst(cpu_inst),
    .inv(inv), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_out1(mem_out1), .mem_out2(mem_out2)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: explicit overrides, else a hash of the block address.
  logic [127:0] mem_ovr [int unsigned];

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] b;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    for (int w = 0; w < 4; w++)
      b[127-32*w -: 32] = ((a + 32'(4*w)) * 32'h9E3779B1) ^ 32'h0BADF00D;
    return b;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input logic [31:0] a);
    int w;
    w = int'((a >> 2) & 32'd3);
    return b[127-32*w -: 32];
  endfunction

  // Memory responder: the block is presented the cycle after mem_read is seen.
  logic        rd_seen = 1'b0;
  logic [31:0] rd_addr = '0;
  always @(negedge clk) begin
    rd_seen = mem_read;
    rd_addr = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    if (rd_seen) begin
      mem_out1 = blk(rd_addr);
      mem_out2 = blk(rd_addr + 32'd16);
    end else begin
      mem_out1 = {$urandom, $urandom, $urandom, $urandom};
      mem_out2 = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Reference model: which block each line holds.
  bit           m_valid [LINES];
  logic [31:0]  m_baddr [LINES];
  logic [127:0] m_data  [LINES];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_baddr[m_idx(a)] == (a & ~32'hF));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_put(input logic [31:0] ba);
    m_valid[m_idx(ba)] = 1'b1;
    m_baddr[m_idx(ba)] = ba;
    m_data[m_idx(ba)]  = blk(ba);
  endtask

  task automatic model_fill(input logic [31:0] a);
    model_put(a & ~32'hF);
`ifdef ICACHE_PREFETCH_EN
    model_put((a & ~32'hF) + 32'd16);
`endif
  endtask

  task automatic do_inv();
    @(negedge clk) inv = 1'b1;
    @(negedge clk) inv = 1'b0;
    model_clear();
  endtask

  // One fetch; inv_cyc=3 pulses inv so it is sampled on the MWAIT edge of a miss.
  task automatic do_fetch(input logic [31:0] a, input int inv_cyc, output int lat);
    bit          exp_hit;
    logic [31:0] exp_inst;
    int          nrd;
    logic [31:0] rd_a;
    int          cyc;
    exp_hit  = m_hit(a);
    exp_inst = exp_hit ? word_of(m_data[m_idx(a)], a) : word_of(blk(a & ~32'hF), a);
    cyc = 0;
    while (cpu_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cpu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: cpu_ready=%b want 1", cpu_ready);
    end
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    nrd = 0; lat = 0; rd_a = '0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cpu_req  = 1'b0;
        cpu_addr = $urandom;
      end
      inv = (cyc == inv_cyc);
      if (mem_read === 1'b1) begin
        nrd++;
        rd_a = mem_addr;
      end
      if (cpu_valid === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    inv = 1'b0;
    n_cmp++;
    if (lat != (exp_hit ? 2 : 4)) begin
      n_err++;
      $display("FAIL latency @%h: got %0d want %0d", a, lat, exp_hit ? 2 : 4);
    end
    n_cmp++;
    if (nrd != (exp_hit ? 0 : 1)) begin
      n_err++;
      $display("FAIL mem_read_count @%h: got %0d want %0d", a, nrd, exp_hit ? 0 : 1);
    end
    if (!exp_hit) begin
      n_cmp++;
      if (rd_a !== (a & ~32'hF)) begin
        n_err++;
        $display("FAIL mem_addr @%h: got %h want %h", a, rd_a, a & ~32'hF);
      end
    end
    n_cmp++;
    if (cpu_inst !== exp_inst) begin
      n_err++;
      $display("FAIL cpu_inst @%h: got %h want %h", a, cpu_inst, exp_inst);
    end
    if (!exp_hit) model_fill(a);
    if (inv_cyc == 3) model_clear();
    @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b1 || cpu_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after_resp @%h: ready=%b valid=%b want 1/0", a, cpu_ready, cpu_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b1 || cpu_valid !== 1'b0 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b valid=%b read=%b want 1/0/0", cpu_ready, cpu_valid, mem_read);
    end
    n_cmp++;
    if (cpu_inst !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: inst=%h addr=%h want 0/0", cpu_inst, mem_addr);
    end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_cold_miss_hit();
    int lat;
    do_fetch(32'h0000_0104, 0, lat);
    n_cmp++;
    if (lat != 4 || cpu_inst !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL cold_miss: lat=%0d inst=%h want 4/22222222", lat, cpu_inst);
    end
    do_fetch(32'h0000_010C, 0, lat);
    n_cmp++;
    if (lat != 2 || cpu_inst !== 32'h4444_4444) begin
      n_err++;
      $display("FAIL refetch_hit: lat=%0d inst=%h want 2/44444444", lat, cpu_inst);
    end
  endtask

  task automatic test_conflict();
    int lat;
    logic [31:0] seq [3];
    seq[0] = 32'h0; seq[1] = 32'h80; seq[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      do_fetch(seq[i], 0, lat);
      n_cmp++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL conflict_miss %0d: lat=%0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_prefetch_wrap();
    int lat;
    do_fetch(32'h0000_0070, 0, lat);
    do_fetch(32'h0000_0080, 0, lat);
    n_cmp++;
`ifdef ICACHE_PREFETCH_EN
    if (lat != 2 || cpu_inst !== 32'hDEAD_BEEF) begin
`else
    if (lat != 4 || cpu_inst !== 32'hDEAD_BEEF) begin
`endif
      n_err++;
      $display("FAIL prefetch_wrap: lat=%0d inst=%h", lat, cpu_inst);
    end
  endtask

  task automatic test_invalidate();
    int lat;
    do_fetch(32'h0000_0104, 0, lat);
    do_fetch(32'h0000_0104, 0, lat);
    n_cmp++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL inv_pre_hit: lat=%0d want 2", lat);
    end
    do_inv();
    do_fetch(32'h0000_0104, 0, lat);
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL inv_idle_miss: lat=%0d want 4", lat);
    end
    do_fetch(32'h0000_0204, 3, lat);
    do_fetch(32'h0000_0204, 0, lat);
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL inv_mwait_miss: lat=%0d want 4", lat);
    end
  endtask

  task automatic test_reset_mid_miss();
    int lat;
    logic [31:0] a;
    a = 32'h0000_0A08;
    do_fetch(32'h0000_0300, 0, lat);
    do_inv();
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk);
    @(negedge clk) cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL mid_miss_read: mem_read=%b want 1", mem_read);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpu_valid !== 1'b0 || mem_read !== 1'b0 || cpu_ready !== 1'b1 ||
        cpu_inst !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL mid_miss_reset: valid=%b read=%b ready=%b inst=%h addr=%h want 0/0/1/0/0",
               cpu_valid, mem_read, cpu_ready, cpu_inst, mem_addr);
    end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_cmp++;
    if (cpu_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stale_resp: cpu_valid=%b want 0", cpu_valid);
    end
    do_fetch(a, 0, lat);
    do_fetch(32'h0000_0300, 0, lat);
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL post_reset_miss: lat=%0d want 4", lat);
    end
  endtask

  task automatic test_ignored_req();
    int nval, nrd, nrdy;
    logic [31:0] a;
    a = 32'h0000_0148;
    do_inv();
    nval = 0; nrd = 0; nrdy = 0;
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cpu_valid === 1'b1) nval++;
      if (mem_read === 1'b1) nrd++;
      if (cpu_ready === 1'b1) nrdy++;
    end
    cpu_req = 1'b0;
    model_fill(a);
    n_cmp++;
    if (nval != 3 || nrd != 1 || nrdy != 2) begin
      n_err++;
      $display("FAIL held_req: valid=%0d read=%0d ready=%0d want 3/1/2", nval, nrd, nrdy);
    end
    n_cmp++;
    if (cpu_inst !== word_of(blk(a & ~32'hF), a)) begin
      n_err++;
      $display("FAIL held_req_inst: got %h want %h", cpu_inst, word_of(blk(a & ~32'hF), a));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, ic;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) do_inv();
      a = $urandom_range(0, 32'h3FF);
      ic = (!m_hit(a) && $urandom_range(0, 5) == 0) ? 3 : 0;
      do_fetch(a, ic, lat);
    end
  endtask

  initial begin
    mem_ovr[32'h100] = 128'h11111111_22222222_33333333_44444444;
    mem_ovr[32'h80]  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    test_reset();
    test_cold_miss_hit();
    test_conflict();
    test_prefetch_wrap();
    test_invalidate();
    test_reset_mid_miss();
    test_ignored_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
